frame_buffer_arbiter: RTL and testbench
=======================================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 16, frame-buffer address width (depth 2**ADDR_WIDTH).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 3, pixel width.
REQ-003 The module SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port vid_rd_req  input  1  video pixel read request.
REQ-006 The module SHALL have port vid_addr  input  ADDR_WIDTH  video read address.
REQ-007 The module SHALL have port vid_rd_valid  output  1  vid_rd_data valid.
REQ-008 The module SHALL have port vid_rd_data  output  DATA_WIDTH  returned pixel.
REQ-009 The module SHALL have port wr_req  input  1  pixel write request, held until acked.
REQ-010 The module SHALL have ports wr_addr  input  ADDR_WIDTH and wr_data  input  DATA_WIDTH  write address and pixel.
REQ-011 The module SHALL have port wr_ack  output  1  write granted this cycle.
REQ-012 The module SHALL have ports clr_start  input  1, clr_color  input  DATA_WIDTH  clear-screen command and fill value.
REQ-013 The module SHALL have ports clr_busy  output  1 and clr_done  output  1  clear in progress; one-cycle completion pulse.
REQ-014 The module SHALL have ports ram_we  output  1, ram_addr  output  ADDR_WIDTH, ram_din  output  DATA_WIDTH, ram_dout  input  DATA_WIDTH  to an external single-port synchronous RAM (registered address, read data valid one cycle after address).

Function
REQ-015 Per-cycle grant priority SHALL be: video read > clear engine (state CLEAR) > writer.
REQ-016 Video grant: ram_addr=vid_addr, ram_we=0; vid_rd_valid SHALL assert exactly one cycle later with vid_rd_data=ram_dout; latency fixed at 1.
REQ-017 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE on the write of address 2**ADDR_WIDTH-1.
REQ-018 On IDLE->CLEAR the clear counter SHALL load 0 and clr_color SHALL be latched; later clr_color changes SHALL not affect the running clear.
REQ-019 Clear grant: ram_we=1, ram_addr=counter, ram_din=latched color; counter increments by 1 only on granted cycles, holds while video preempts.
REQ-020 clr_done SHALL pulse one cycle, the cycle after the final clear write; clr_busy SHALL equal (state==CLEAR).
REQ-021 clr_start while in CLEAR SHALL be ignored.
REQ-022 Writer grant: only when no video request and state IDLE; ram_we=1, ram_addr=wr_addr, ram_din=wr_data, wr_ack=1 combinationally in the same cycle; write commits on that edge.
REQ-023 wr_req SHALL never be acked during CLEAR or while vid_rd_req=1.
REQ-024 No grant: ram_we=0, ram_addr holds last value, outputs otherwise idle.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, vid_rd_valid=0, clr_busy=0, clr_done=0, ram_we=0 (wr_ack=0 while in reset).
REQ-026 Reset mid-clear SHALL abort the clear with no clr_done pulse; RAM contents are undefined, not restored.

Structure
REQ-027 A shared package fb_pkg SHALL hold the state enum (IDLE, CLEAR) and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-028 The clear address counter (load, enable, terminal-count flag) SHALL be a sub-module fb_addr_counter; the arbiter and FSM stay in the top.

Verification (ADDR_WIDTH=4 bench, RAM model attached)
REQ-029 Write wr_addr=5, wr_data=3'b110 with no video -> wr_ack same cycle; later video read addr 5 -> vid_rd_valid next cycle, data 3'b110.
REQ-030 vid_rd_req and wr_req both high 3 cycles -> 3 video reads, wr_ack=0 throughout, ack on the 4th cycle.
REQ-031 clr_start with clr_color=3'b010, no traffic -> clr_busy 16 cycles, clr_done pulse on cycle 17, all 16 locations read back 3'b010.
REQ-032 Clear with video requests on 4 interleaved cycles -> clear completes in 20 cycles, no address skipped or repeated, video data correct.
REQ-033 clr_start again at counter=7, and wr_req held during clear -> both ignored until clr_done; wr_ack one cycle after CLEAR exits.
REQ-034 rst_n low at counter=9 -> outputs reset asynchronously, no clr_done, clr_busy=0, next clr_start restarts at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and default widths for the frame buffer arbiter
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 16;
  localparam int FB_DATA_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// rtl/frame_buffer_arbiter_if.sv - single-port synchronous RAM bus between arbiter and frame buffer
interface frame_buffer_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
);

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output ram_we,
    output ram_addr,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_addr,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/fb_addr_counter.sv
// rtl/fb_addr_counter.sv - clear-screen address counter with synchronous load-to-zero and terminal flag
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int WIDTH = FB_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = &count;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - shares one RAM port between video reads, a clear-screen engine and a pixel writer
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vid_rd_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_rd_valid,
  output logic [DATA_WIDTH-1:0] vid_rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_color,
  output logic                  clr_busy,
  output logic                  clr_done,
  frame_buffer_arbiter_if.master ram
);

  fb_state_e             state_q;
  fb_state_e             state_d;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  cnt_tc;
  logic                  cnt_load;
  logic                  clr_grant;
  logic                  wr_grant;
  logic [DATA_WIDTH-1:0] color_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  vid_valid_q;
  logic                  done_q;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  fb_addr_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (clr_grant),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      color_q     <= '0;
      addr_q      <= '0;
      vid_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= sel_addr;
      vid_valid_q <= vid_rd_req;
      done_q      <= clr_grant && cnt_tc;
      if (cnt_load) begin
        color_q <= clr_color;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    clr_grant = 1'b0;
    wr_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        wr_grant = wr_req && !vid_rd_req;
        if (clr_start) begin
          state_d  = CLEAR;
          cnt_load = 1'b1;
        end
      end
      CLEAR: begin
        clr_grant = !vid_rd_req;
        if (clr_grant && cnt_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Video always wins the port; an ungranted cycle leaves the address where it was.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = addr_q;
    sel_din  = '0;
    if (vid_rd_req) begin
      sel_addr = vid_addr;
    end else if (clr_grant) begin
      sel_we   = 1'b1;
      sel_addr = cnt;
      sel_din  = color_q;
    end else if (wr_grant) begin
      sel_we   = 1'b1;
      sel_addr = wr_addr;
      sel_din  = wr_data;
    end
  end

  assign ram.ram_we   = sel_we && rst_n;
  assign ram.ram_addr = sel_addr;
  assign ram.ram_din  = sel_din;
  assign wr_ack       = wr_grant && rst_n;
  assign clr_busy     = (state_q == CLEAR);
  assign clr_done     = done_q;
  assign vid_rd_valid = vid_valid_q;
  assign vid_rd_data  = ram.ram_dout;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - directed and random checks of frame_buffer_arbiter against a behavioural model
module tb_frame_buffer_arbiter;

  localparam int AW = 4;
  localparam int DW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_rd_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rd_valid;
  logic [DW-1:0] vid_rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [DEPTH] = '{default: '0};

  logic [DW-1:0] m_mem [DEPTH] = '{default: '0};
  logic          m_busy = 1'b0;
  int            m_idx = 0;
  logic [DW-1:0] m_color = '0;

  frame_buffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram ();

  frame_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vid_rd_req   (vid_rd_req),
    .vid_addr     (vid_addr),
    .vid_rd_valid (vid_rd_valid),
    .vid_rd_data  (vid_rd_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .clr_start    (clr_start),
    .clr_color    (clr_color),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .ram          (ram.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_din;
    ram.ram_dout <= mem[ram.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the bus: grants are checked mid-cycle, registered outputs just after the edge.
  task automatic cycle();
    logic          exp_ack;
    logic          exp_cg;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_done;
    @(negedge clk);
    exp_ack = wr_req && !vid_rd_req && !m_busy;
    exp_cg  = m_busy && !vid_rd_req;
    check("wr_ack", 32'(wr_ack), 32'(exp_ack));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
    check("ram_we", 32'(ram.ram_we), 32'(exp_ack || exp_cg));
    if (vid_rd_req) check("vid_ram_addr", 32'(ram.ram_addr), 32'(vid_addr));
    if (exp_cg) begin
      check("clr_ram_addr", 32'(ram.ram_addr), 32'(m_idx));
      check("clr_ram_din", 32'(ram.ram_din), 32'(m_color));
    end
    if (exp_ack) begin
      check("wr_ram_addr", 32'(ram.ram_addr), 32'(wr_addr));
      check("wr_ram_din", 32'(ram.ram_din), 32'(wr_data));
    end
    exp_valid = vid_rd_req;
    exp_data  = m_mem[vid_addr];
    exp_done  = 1'b0;
    if (exp_ack) m_mem[wr_addr] = wr_data;
    if (exp_cg) begin
      m_mem[m_idx] = m_color;
      if (m_idx == DEPTH - 1) begin
        m_busy   = 1'b0;
        exp_done = 1'b1;
      end else begin
        m_idx++;
      end
    end else if (!m_busy && clr_start) begin
      m_busy  = 1'b1;
      m_idx   = 0;
      m_color = clr_color;
    end
    @(posedge clk);
    #1;
    check("vid_rd_valid", 32'(vid_rd_valid), 32'(exp_valid));
    if (exp_valid) check("vid_rd_data", 32'(vid_rd_data), 32'(exp_data));
    check("clr_done", 32'(clr_done), 32'(exp_done));
  endtask

  task automatic idle_inputs();
    vid_rd_req = 1'b0;
    wr_req     = 1'b0;
    clr_start  = 1'b0;
  endtask

  task automatic readback();
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      vid_rd_req = 1'b1;
      vid_addr   = AW'(a);
      cycle();
    end
    vid_rd_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    while (m_busy && n < 40) begin
      cycle();
      n++;
    end
    check("drain_busy", 32'(clr_busy), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle_inputs();
    vid_addr = '0; wr_addr = '0; wr_data = '0; clr_color = '0;
    wr_req = 1'b1;
    #2;
    check("rst_wr_ack", 32'(wr_ack), 32'(0));
    check("rst_ram_we", 32'(ram.ram_we), 32'(0));
    check("rst_clr_busy", 32'(clr_busy), 32'(0));
    check("rst_clr_done", 32'(clr_done), 32'(0));
    check("rst_vid_valid", 32'(vid_rd_valid), 32'(0));
    wr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    wr_req = 1'b1; wr_addr = 4'd5; wr_data = 3'b110;
    cycle();
    wr_req = 1'b0;
    cycle();
    vid_rd_req = 1'b1; vid_addr = 4'd5;
    cycle();
    check("px5_data", 32'(vid_rd_data), 32'(3'b110));
    check("px5_valid", 32'(vid_rd_valid), 32'(1));

    vid_rd_req = 1'b1; wr_req = 1'b1; wr_addr = 4'd9; wr_data = 3'b011;
    for (int i = 0; i < 3; i++) begin
      vid_addr = AW'(i);
      cycle();
    end
    vid_rd_req = 1'b0;
    @(negedge clk);
    check("fourth_ack", 32'(wr_ack), 32'(1));
    cycle();
    wr_req = 1'b0;

    clr_start = 1'b1; clr_color = 3'b010;
    cycle();
    clr_start = 1'b0; clr_color = 3'b111;
    n = 0;
    while (m_busy && n < 40) begin
      cycle();
      n++;
    end
    check("clr_cycles", 32'(n), 32'(16));
    check("clr_done_pulse", 32'(clr_done), 32'(1));
    readback();

    clr_start = 1'b1; clr_color = 3'b101;
    cycle();
    clr_start = 1'b0;
    n = 0;
    while (m_busy && n < 40) begin
      vid_rd_req = (n % 2 == 1) && (n < 8);
      vid_addr   = AW'(15 - n);
      cycle();
      n++;
    end
    vid_rd_req = 1'b0;
    check("clr_vid_cycles", 32'(n), 32'(20));
    readback();

    clr_start = 1'b1; clr_color = 3'b001;
    cycle();
    clr_start = 1'b0; wr_req = 1'b1; wr_addr = 4'd2; wr_data = 3'b100;
    n = 0;
    while (m_busy && n < 40) begin
      clr_start = (m_idx == 7);
      clr_color = 3'b110;
      cycle();
      n++;
    end
    clr_start = 1'b0;
    check("restart_ignored_cycles", 32'(n), 32'(16));
    @(negedge clk);
    check("ack_after_clear", 32'(wr_ack), 32'(1));
    cycle();
    wr_req = 1'b0;
    readback();

    clr_start = 1'b1; clr_color = 3'b011;
    cycle();
    clr_start = 1'b0; wr_req = 1'b1; wr_addr = 4'd1;
    n = 0;
    while (m_idx != 9 && n < 40) begin
      cycle();
      n++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_clr_busy", 32'(clr_busy), 32'(0));
    check("midrst_clr_done", 32'(clr_done), 32'(0));
    check("midrst_ram_we", 32'(ram.ram_we), 32'(0));
    check("midrst_wr_ack", 32'(wr_ack), 32'(0));
    check("midrst_vid_valid", 32'(vid_rd_valid), 32'(0));
    m_busy = 1'b0;
    m_idx  = 0;
    wr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_clr_done", 32'(clr_done), 32'(0));
    clr_start = 1'b1; clr_color = 3'b100;
    cycle();
    clr_start = 1'b0;
    drain();
    readback();

    for (int i = 0; i < 400; i++) begin
      vid_rd_req = ($urandom % 3) == 0;
      vid_addr   = AW'($urandom);
      wr_req     = ($urandom % 2) == 0;
      wr_addr    = AW'($urandom);
      wr_data    = DW'($urandom);
      clr_start  = ($urandom % 25) == 0;
      clr_color  = DW'($urandom);
      cycle();
    end
    drain();
    readback();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
